// File: rtl/switch_out_arbiter_if.sv
// Bundle between the input ports, the output-port arbiter and the downstream reader.
// The arbiter uses the slave modport; the input-side driver uses master.
interface switch_out_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int DW     = 8
);
    logic [NPORTS-1:0]    req;
    logic [NPORTS*DW-1:0] data_in;
    logic [NPORTS-1:0]    rcv_rdy;
    logic [DW-1:0]        data_out;
    logic                 valid_out;
    logic                 data_rd;
    logic [NPORTS-1:0]    gnt;
    logic                 busy;

    modport master (
        output req, data_in, data_rd,
        input  rcv_rdy, data_out, valid_out, gnt, busy
    );

    modport slave (
        input  req, data_in, data_rd,
        output rcv_rdy, data_out, valid_out, gnt, busy
    );
endinterface

// File: rtl/switch_out_arbiter.sv
// Round-robin arbiter for one switch output port, with a one-byte output register.
// Grants last until the owner drops req or MAX_BURST bytes have moved.
module switch_out_arbiter #(
    parameter int NPORTS    = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                reset,
    switch_out_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | no owner; pick next requester round-robin after ptr
    // XFER  | owner in gnt moves bytes into the output register
    typedef enum logic {IDLE, XFER} state_t;

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [7:0] MB = 8'(MAX_BURST);

    state_t            state_q, state_d;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              vout_q, vout_d;

    logic [PW-1:0]     own_idx;
    logic [PW-1:0]     win_idx;
    logic              win_found;
    logic              owner_req;
    logic              xfer_ok;
    logic [DW-1:0]     owner_byte;
    logic [7:0]        cnt_inc;
    int                idx;

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt_q[i]) own_idx = PW'(i);
        end
    end

    // Search ptr+1, ptr+2, ... so the last owner has lowest priority
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(ptr_q) + k) % NPORTS;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign owner_req  = bus.req[own_idx];
    assign owner_byte = bus.data_in[int'(own_idx)*DW +: DW];
    assign cnt_inc    = cnt_q + 8'd1;
    // reset gating keeps rcv_rdy low during the cycle a reset is being applied
    assign xfer_ok    = (state_q == XFER) && owner_req && (!vout_q || bus.data_rd) && reset;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vout_d  = vout_q;
        if (vout_q && bus.data_rd) vout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (win_found) begin
                    state_d        = XFER;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            XFER: begin
                if (xfer_ok) begin
                    dout_d = owner_byte;
                    vout_d = 1'b1;
                    cnt_d  = cnt_inc;
                end
                if (!owner_req || (xfer_ok && cnt_inc == MB)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = own_idx;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(NPORTS - 1);
            cnt_q   <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
        end
    end

    assign bus.rcv_rdy   = xfer_ok ? gnt_q : '0;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == XFER);
    assign bus.data_out  = dout_q;
    assign bus.valid_out = vout_q;
endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter: default instance plus a MAX_BURST=1 instance.
module tb_switch_out_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    switch_out_arbiter_if #(.NPORTS(4), .DW(8)) a ();
    switch_out_arbiter_if #(.NPORTS(4), .DW(8)) b ();

    switch_out_arbiter #(.NPORTS(4), .DW(8), .MAX_BURST(16)) dut_a (
        .clk(clk), .reset(reset), .bus(a)
    );
    switch_out_arbiter #(.NPORTS(4), .DW(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        a.req = '0; a.data_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; a.data_rd = 1'b0;
        b.req = '0; b.data_in = '0; b.data_rd = 1'b0;

        // reset state
        step(); step();
        a.req = 4'hF; #1;
        chk("rst_gnt",   32'(a.gnt), 32'(4'b0000));
        chk("rst_valid", 32'(a.valid_out), 32'(1'b0));
        chk("rst_dout",  32'(a.data_out), 32'(8'h00));
        chk("rst_busy",  32'(a.busy), 32'(1'b0));
        chk("rst_rdy",   32'(a.rcv_rdy), 32'(4'b0000));
        chk("rst_gnt_b", 32'(b.gnt), 32'(4'b0000));

        // port 2 sends A1,A2,A3 then drops req
        step(); reset = 1'b1; a.req = 4'b0100; a.data_in[16 +: 8] = 8'hA1; a.data_rd = 1'b1; #1;
        chk("p2_idle_gnt", 32'(a.gnt), 32'(4'b0000));
        chk("p2_idle_rdy", 32'(a.rcv_rdy), 32'(4'b0000));
        step(); #1;
        chk("p2_gnt",   32'(a.gnt), 32'(4'b0100));
        chk("p2_busy",  32'(a.busy), 32'(1'b1));
        chk("p2_rdy1",  32'(a.rcv_rdy), 32'(4'b0100));
        chk("p2_nov",   32'(a.valid_out), 32'(1'b0));
        step(); a.data_in[16 +: 8] = 8'hA2; #1;
        chk("p2_d1", 32'(a.data_out), 32'(8'hA1));
        chk("p2_v1", 32'(a.valid_out), 32'(1'b1));
        chk("p2_rdy2", 32'(a.rcv_rdy), 32'(4'b0100));
        step(); a.data_in[16 +: 8] = 8'hA3; #1;
        chk("p2_d2", 32'(a.data_out), 32'(8'hA2));
        chk("p2_v2", 32'(a.valid_out), 32'(1'b1));
        step(); a.req = 4'b0000; #1;
        chk("p2_d3", 32'(a.data_out), 32'(8'hA3));
        chk("p2_v3", 32'(a.valid_out), 32'(1'b1));
        chk("p2_drop_rdy", 32'(a.rcv_rdy), 32'(4'b0000));
        step(); a.req = 4'hF; #1;
        chk("p2_end_gnt",  32'(a.gnt), 32'(4'b0000));
        chk("p2_end_busy", 32'(a.busy), 32'(1'b0));
        chk("p2_end_v",    32'(a.valid_out), 32'(1'b0));
        chk("p2_end_hold", 32'(a.data_out), 32'(8'hA3));
        step(); a.req = 4'b0000; #1;
        chk("ptr2_next", 32'(a.gnt), 32'(4'b1000));

        // ptr=3, req=1001: port 0 first, then wrap to port 3
        step(); a.data_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; a.req = 4'b1001; #1;
        chk("wrap_idle", 32'(a.gnt), 32'(4'b0000));
        step(); #1;
        chk("wrap_first", 32'(a.gnt), 32'(4'b0001));
        chk("wrap_rdy",   32'(a.rcv_rdy), 32'(4'b0001));
        step(); a.req = 4'b1000; #1;
        chk("wrap_d0", 32'(a.data_out), 32'(8'hD0));
        chk("wrap_v0", 32'(a.valid_out), 32'(1'b1));
        step(); #1;
        chk("wrap_bubble", 32'(a.gnt), 32'(4'b0000));
        chk("wrap_drain",  32'(a.valid_out), 32'(1'b0));
        step(); a.req = 4'b0000; #1;
        chk("wrap_second", 32'(a.gnt), 32'(4'b1000));

        // port 1 stalled by data_rd=0 for 5 cycles, non-owner req toggling
        step(); a.req = 4'b0010; #1;
        step(); #1;
        chk("stall_gnt", 32'(a.gnt), 32'(4'b0010));
        chk("stall_rdy0", 32'(a.rcv_rdy), 32'(4'b0010));
        step(); a.data_rd = 1'b0; a.data_in[8 +: 8] = 8'hB1; #1;
        chk("stall_d_0", 32'(a.data_out), 32'(8'hD1));
        chk("stall_v_0", 32'(a.valid_out), 32'(1'b1));
        chk("stall_r_0", 32'(a.rcv_rdy), 32'(4'b0000));
        for (int i = 1; i < 5; i++) begin
            step();
            if (i == 2) a.req = 4'b1011;
            #1;
            chk("stall_d", 32'(a.data_out), 32'(8'hD1));
            chk("stall_v", 32'(a.valid_out), 32'(1'b1));
            chk("stall_r", 32'(a.rcv_rdy), 32'(4'b0000));
            chk("stall_g", 32'(a.gnt), 32'(4'b0010));
        end
        step(); a.data_rd = 1'b1; a.req = 4'b0010; #1;
        chk("resume_rdy", 32'(a.rcv_rdy), 32'(4'b0010));
        chk("resume_d",   32'(a.data_out), 32'(8'hD1));
        step(); a.req = 4'b0000; #1;
        chk("resume_d2", 32'(a.data_out), 32'(8'hB1));
        chk("resume_v2", 32'(a.valid_out), 32'(1'b1));

        // reset mid-burst during 2nd byte of port 0
        step(); a.data_in[8 +: 8] = 8'hD1; a.req = 4'b0001; #1;
        chk("mrst_idle", 32'(a.gnt), 32'(4'b0000));
        step(); #1;
        chk("mrst_gnt", 32'(a.gnt), 32'(4'b0001));
        step(); reset = 1'b0; #1;
        chk("mrst_no_rdy", 32'(a.rcv_rdy), 32'(4'b0000));
        step(); #1;
        chk("mrst_gnt0", 32'(a.gnt), 32'(4'b0000));
        chk("mrst_v0",   32'(a.valid_out), 32'(1'b0));
        chk("mrst_d0",   32'(a.data_out), 32'(8'h00));
        chk("mrst_b0",   32'(a.busy), 32'(1'b0));
        reset = 1'b1; a.req = 4'b0010;
        step(); a.req = 4'b0000; #1;
        chk("mrst_p1", 32'(a.gnt), 32'(4'b0010));

        // all four request continuously: 0,1,2,3,0 with 16 bytes each and a bubble
        step(); reset = 1'b0; #1;
        step(); reset = 1'b1; a.req = 4'hF; a.data_rd = 1'b1; #1;
        chk("rr_idle", 32'(a.gnt), 32'(4'b0000));
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int j = 1; j <= 16; j++) begin
                step(); #1;
                chk("rr_gnt", 32'(a.gnt), 32'(exp_g));
                chk("rr_rdy", 32'(a.rcv_rdy), 32'(exp_g));
                if (j == 1) chk("rr_first_v", 32'(a.valid_out), 32'(1'b0));
                else        chk("rr_data", 32'(a.data_out), 32'(8'hD0 + (g % 4)));
            end
            step(); #1;
            chk("rr_bubble", 32'(a.gnt), 32'(4'b0000));
            chk("rr_bubble_busy", 32'(a.busy), 32'(1'b0));
            chk("rr_last", 32'(a.data_out), 32'(8'hD0 + (g % 4)));
            chk("rr_last_v", 32'(a.valid_out), 32'(1'b1));
        end
        a.req = 4'b0000;

        // MAX_BURST=1: one byte per grant, gnt alternates 0001/0000
        step(); b.req = 4'b0001; b.data_rd = 1'b1; b.data_in[7:0] = 8'h40; #1;
        chk("mb1_idle", 32'(b.gnt), 32'(4'b0000));
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0) begin
                b.data_in[7:0] = 8'(8'h50 + i); #1;
                chk("mb1_gnt", 32'(b.gnt), 32'(4'b0001));
                chk("mb1_rdy", 32'(b.rcv_rdy), 32'(4'b0001));
            end else begin
                #1;
                chk("mb1_bubble", 32'(b.gnt), 32'(4'b0000));
                chk("mb1_busy",   32'(b.busy), 32'(1'b0));
                chk("mb1_data",   32'(b.data_out), 32'(8'h50 + i - 1));
                chk("mb1_v",      32'(b.valid_out), 32'(1'b1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_out_arbiter.md
SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

Interface
REQ-001 Parameter NPORTS, default 4: number of input ports competing for this output port.
REQ-002 Parameter DW, default 8: byte width per port; data_in width is NPORTS*DW.
REQ-003 Parameter MAX_BURST, default 16: maximum bytes per grant before forced re-arbitration; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 req  input  NPORTS  req[i]=1: input port i presents a byte destined for this output.
REQ-007 data_in  input  NPORTS*DW  byte for port i at data_in[DW*i+DW-1 : DW*i].
REQ-008 rcv_rdy  output  NPORTS  rcv_rdy[i]=1: byte of port i is accepted this cycle.
REQ-009 data_out  output  DW  registered output byte.
REQ-010 valid_out  output  1  data_out holds an unconsumed byte.
REQ-011 data_rd  input  1  downstream read strobe; a byte is consumed when valid_out && data_rd at posedge.
REQ-012 gnt  output  NPORTS  one-hot current owner, all-zero when no owner.
REQ-013 busy  output  1  equals (state == XFER).

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-015 In IDLE with req != 0, the block SHALL pick the first requester searching ptr+1, ptr+2, ... modulo NPORTS, register it one-hot into gnt and enter XFER on the next edge.
REQ-016 In IDLE, gnt SHALL be 0 and rcv_rdy SHALL be 0.
REQ-017 In XFER with owner g, rcv_rdy[g] SHALL be req[g] && (!valid_out || data_rd), combinational; all other rcv_rdy bits SHALL be 0.
REQ-018 On a transfer (req[g] && rcv_rdy[g]), data_out SHALL load byte g, valid_out SHALL be 1 and burst_cnt SHALL increment at the edge.
REQ-019 With valid_out && data_rd and no transfer, valid_out SHALL clear; data_out SHALL hold its value.
REQ-020 With valid_out && !data_rd, data_out and valid_out SHALL hold stable (stall) and no byte SHALL be accepted.
REQ-021 In XFER, req[g]==0 at an edge SHALL end the packet: state goes to IDLE, gnt clears, ptr loads g, burst_cnt clears.
REQ-022 A transfer that brings burst_cnt to MAX_BURST SHALL end the grant at that same edge, identically to REQ-021.
REQ-023 Re-arbitration latency: a request in cycle n from IDLE SHALL see gnt in cycle n+1, first rcv_rdy in n+1 if the output is free, and valid_out in n+2.
REQ-024 Each grant SHALL be followed by at least one IDLE cycle, the re-arbitration bubble.
REQ-025 ptr SHALL wrap from NPORTS-1 to 0; a lone requester SHALL be re-granted after each bubble.
REQ-026 gnt SHALL never have more than one bit set; req changes of non-owners SHALL not affect XFER.
REQ-027 valid_out and data_out SHALL continue to drain via data_rd while in IDLE.

Reset
REQ-028 With reset==0 at an edge: state=IDLE, gnt=0, ptr=NPORTS-1 (port 0 has first priority), burst_cnt=0, data_out=0, valid_out=0, busy=0; rcv_rdy=0 combinationally thereafter.
REQ-029 Reset asserted mid-XFER SHALL discard the held byte and grant; no rcv_rdy SHALL assert in the reset cycle.

Verification
REQ-030 Reset, then req=4'b1111 with data_rd=1 tied high -> grants in order 0,1,2,3,0 with a 1-cycle bubble between grants; each port moves MAX_BURST=16 bytes per grant.
REQ-031 req[2]=1 for 3 bytes (0xA1,0xA2,0xA3), then drop -> data_out sequence A1,A2,A3 with valid_out in cycles n+2..n+4; gnt=4'b0100 ends, ptr=2.
REQ-032 Owner port 1 sending, data_rd=0 for 5 cycles -> data_out stays constant, valid_out=1, rcv_rdy[1]=0 for all 5 cycles; transfer resumes the cycle data_rd=1.
REQ-033 ptr=3, req=4'b1001 -> port 0 is granted; after it ends, port 3 is granted (wrap check).
REQ-034 reset driven low during the 2nd byte of a burst -> next cycle gnt=0, valid_out=0, data_out=0, busy=0; after release with req=4'b0010, port 1 is granted.
REQ-035 MAX_BURST=1, req=4'b0001 held -> exactly one byte per grant, with gnt toggling 0001/0000 on alternate cycles.
